// File: rtl/audio_dac_tx.sv
// audio_dac_tx -- streaming I2S transmitter for the codec DAC path.
//
// Stereo frames arrive over a valid/ready handshake, are buffered in a small
// FIFO and are serialised MSB-first onto DACDAT. The codec is bus master:
// BCLK and DACLRCK are inputs, oversampled by clk_clk (>= 4x BCLK).
//
// Optional feature macro: AUDIO_DAC_TX_UFLOW_CNT_EN adds the saturating
// 16-bit underflow_count output.
//
// Ports:
//   clk_clk            system clock
//   reset_reset        synchronous, active-high reset
//   sample_left/right  two's complement channel samples (DATA_WIDTH bits)
//   sample_valid       frame on sample_left/right is valid
//   sample_ready       FIFO can accept a frame
//   fifo_level         frames currently stored
//   underflow          one-cycle pulse when a left slot starts with FIFO empty
//   audio_out_BCLK     codec bit clock (asynchronous)
//   audio_out_DACLRCK  codec word clock (asynchronous), low = left
//   audio_out_DACDAT   serial data to codec
//   underflow_count    saturating underflow counter (macro only)
module audio_dac_tx #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                         clk_clk,
   input  logic                         reset_reset,
   input  logic [DATA_WIDTH-1:0]        sample_left,
   input  logic [DATA_WIDTH-1:0]        sample_right,
   input  logic                         sample_valid,
   output logic                         sample_ready,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         underflow,
   input  logic                         audio_out_BCLK,
   input  logic                         audio_out_DACLRCK,
   output logic                         audio_out_DACDAT
`ifdef AUDIO_DAC_TX_UFLOW_CNT_EN
   ,
   output logic [15:0]                  underflow_count
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      ST_UNALIGNED,
      ST_LEFT,
      ST_RIGHT
   } state_e;

   // ------------------------------------------------------------------
   // Pin synchronisers and registered edge detectors
   // ------------------------------------------------------------------
   logic [1:0] bclk_sync_q, lrck_sync_q;
   logic       bclk_prev_q, lrck_prev_q;
   logic       bclk_fall_q, lrck_fall_q, lrck_rise_q;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         bclk_sync_q <= '0;
         lrck_sync_q <= '0;
         bclk_prev_q <= 1'b0;
         lrck_prev_q <= 1'b0;
         bclk_fall_q <= 1'b0;
         lrck_fall_q <= 1'b0;
         lrck_rise_q <= 1'b0;
      end else begin
         bclk_sync_q <= {bclk_sync_q[0], audio_out_BCLK};
         lrck_sync_q <= {lrck_sync_q[0], audio_out_DACLRCK};
         bclk_prev_q <= bclk_sync_q[1];
         lrck_prev_q <= lrck_sync_q[1];
         bclk_fall_q <= bclk_prev_q & ~bclk_sync_q[1];
         lrck_fall_q <= lrck_prev_q & ~lrck_sync_q[1];
         lrck_rise_q <= ~lrck_prev_q & lrck_sync_q[1];
      end
   end

   // ------------------------------------------------------------------
   // Frame FIFO
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           count_q;
   logic                  full, empty, push, pop;

   assign full         = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty        = (count_q == '0);
   assign sample_ready = !full && !reset_reset;
   assign push         = sample_valid && sample_ready;
   // Pop decision uses the registered count only, so a same-cycle push
   // into an empty FIFO is never visible to this pop.
   assign pop          = lrck_fall_q && !empty;

   always_ff @(posedge clk_clk) begin
      if (push) begin
         mem_l[wr_ptr_q] <= sample_left;
         mem_r[wr_ptr_q] <= sample_right;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign fifo_level = count_q;

   // ------------------------------------------------------------------
   // Slot state machine and shifter
   // ------------------------------------------------------------------
   state_e                state_q;
   logic [DATA_WIDTH-1:0] shreg_q, hold_q;
   logic [CW-1:0]         bit_cnt_q;
   logic                  dacdat_q, underflow_q;

   // Slot loads win over a coincident bclk_fall; skipping that shift is
   // what produces the one-BCLK I2S delay before the MSB.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q     <= ST_UNALIGNED;
         shreg_q     <= '0;
         hold_q      <= '0;
         bit_cnt_q   <= '0;
         dacdat_q    <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         underflow_q <= 1'b0;
         if (lrck_fall_q) begin
            state_q   <= ST_LEFT;
            bit_cnt_q <= CW'(DATA_WIDTH);
            if (!empty) begin
               shreg_q <= mem_l[rd_ptr_q];
               hold_q  <= mem_r[rd_ptr_q];
            end else begin
               shreg_q     <= '0;
               hold_q      <= '0;
               underflow_q <= 1'b1;
            end
         end else if (lrck_rise_q && state_q != ST_UNALIGNED) begin
            state_q   <= ST_RIGHT;
            shreg_q   <= hold_q;
            bit_cnt_q <= CW'(DATA_WIDTH);
         end else if (bclk_fall_q && state_q != ST_UNALIGNED) begin
            if (bit_cnt_q != '0) begin
               dacdat_q  <= shreg_q[DATA_WIDTH-1];
               shreg_q   <= {shreg_q[DATA_WIDTH-2:0], 1'b0};
               bit_cnt_q <= bit_cnt_q - CW'(1);
            end else begin
               dacdat_q <= 1'b0;
            end
         end
      end
   end

   assign audio_out_DACDAT = dacdat_q;
   assign underflow        = underflow_q;

`ifdef AUDIO_DAC_TX_UFLOW_CNT_EN
   logic [15:0] uflow_cnt_q;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         uflow_cnt_q <= '0;
      end else if (underflow_q && uflow_cnt_q != 16'hFFFF) begin
         uflow_cnt_q <= uflow_cnt_q + 16'd1;
      end
   end

   assign underflow_count = uflow_cnt_q;
`endif

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx -- directed bench for audio_dac_tx.
//
// A behavioural codec master drives BCLK (16 clk_clk per period) and
// DACLRCK (32 BCLK per half-frame), changing DACLRCK on BCLK falling edges,
// and samples DACDAT on each BCLK rising edge. Build with
// AUDIO_DAC_TX_UFLOW_CNT_EN defined to exercise underflow_count as well.
module tb_audio_dac_tx;

   localparam int unsigned DW = 16;
   localparam int unsigned FD = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_left = '0;
   logic [DW-1:0] s_right = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [3:0]    level;
   logic          uflow;
   logic          bclk = 1'b1;
   logic          lrck = 1'b1;
   logic          dacdat;
`ifdef AUDIO_DAC_TX_UFLOW_CNT_EN
   logic [15:0]   ucount;
`endif

   int checks = 0;
   int errors = 0;
   int uf_cycles = 0;

   audio_dac_tx #(
      .DATA_WIDTH(DW),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk_clk          (clk),
      .reset_reset      (rst),
      .sample_left      (s_left),
      .sample_right     (s_right),
      .sample_valid     (s_valid),
      .sample_ready     (s_ready),
      .fifo_level       (level),
      .underflow        (uflow),
      .audio_out_BCLK   (bclk),
      .audio_out_DACLRCK(lrck),
      .audio_out_DACDAT (dacdat)
`ifdef AUDIO_DAC_TX_UFLOW_CNT_EN
      ,
      .underflow_count  (ucount)
`endif
   );

   always #10 clk = ~clk;

   // Counts every clock cycle in which underflow is high.
   always @(posedge clk) begin
      if (uflow === 1'b1) uf_cycles <= uf_cycles + 1;
   end

   // Expected 32-bit slot capture: one delay bit, the sample, then zeros.
   function automatic logic [31:0] exp_word(input logic [DW-1:0] d);
      return {1'b0, d, 15'b0};
   endfunction

   // One BCLK period starting at its falling edge; called at a negedge of clk.
   task automatic bclk_bit(input logic set_lr, input logic lr, output logic b);
      bclk = 1'b0;
      if (set_lr) lrck = lr;
      repeat (8) @(negedge clk);
      bclk = 1'b1;
      b = dacdat;
      repeat (8) @(negedge clk);
   endtask

   task automatic run_slot(input logic lr, output logic [31:0] w);
      logic b;
      for (int i = 0; i < 32; i++) begin
         bclk_bit(i == 0, lr, b);
         w[31-i] = b;
      end
   endtask

   task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
      s_left  = l;
      s_right = r;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic test_reset;
      int u0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL rst_dacdat got %b expected 0", dacdat); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b expected 0", s_ready); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d expected 0", level); end
      checks++; if (uflow !== 1'b0) begin errors++; $display("FAIL rst_underflow got %b expected 0", uflow); end
`ifdef AUDIO_DAC_TX_UFLOW_CNT_EN
      checks++; if (ucount !== 16'd0) begin errors++; $display("FAIL rst_ucount got %h expected 0000", ucount); end
`endif
      rst = 1'b0;
      @(negedge clk);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b expected 1", s_ready); end
      u0 = uf_cycles;
      repeat (20) @(negedge clk);
      checks++; if (uf_cycles - u0 !== 0) begin errors++; $display("FAIL idle_underflow got %0d expected 0", uf_cycles - u0); end
      checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL idle_dacdat got %b expected 0", dacdat); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL idle_level got %0d expected 0", level); end
   endtask

   task automatic test_single_frame;
      logic [31:0] w;
      int u0;
      u0 = uf_cycles;
      push_frame(16'h8001, 16'h7FFE);
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL one_level got %0d expected 1", level); end
      run_slot(1'b0, w);
      checks++; if (w !== 32'h4000_8000) begin errors++; $display("FAIL one_left got %h expected 40008000", w); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL one_level_pop got %0d expected 0", level); end
      run_slot(1'b1, w);
      checks++; if (w !== 32'h3FFF_0000) begin errors++; $display("FAIL one_right got %h expected 3fff0000", w); end
      checks++; if (uf_cycles - u0 !== 0) begin errors++; $display("FAIL one_underflow got %0d expected 0", uf_cycles - u0); end
   endtask

   task automatic test_fill;
      logic [31:0] w;
      logic [DW-1:0] l, r;
      s_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_left  = 16'hA000 | 16'(i);
         s_right = 16'h5000 | 16'(i);
         if (i == 7) begin
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_ready7 got %b expected 1", s_ready); end
            checks++; if (level !== 4'd7) begin errors++; $display("FAIL fill_level7 got %0d expected 7", level); end
         end
         @(negedge clk);
      end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_ready8 got %b expected 0", s_ready); end
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL fill_level8 got %0d expected 8", level); end
      // Ninth frame held valid: refused until the next left-slot pop.
      s_left  = 16'hA008;
      s_right = 16'h5008;
      repeat (5) @(negedge clk);
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL fill_ninth_blocked got %0d expected 8", level); end
      run_slot(1'b0, w);
      s_valid = 1'b0;
      checks++; if (w !== exp_word(16'hA000)) begin errors++; $display("FAIL fill_left0 got %h expected %h", w, exp_word(16'hA000)); end
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL fill_level_refill got %0d expected 8", level); end
      run_slot(1'b1, w);
      checks++; if (w !== exp_word(16'h5000)) begin errors++; $display("FAIL fill_right0 got %h expected %h", w, exp_word(16'h5000)); end
      for (int i = 1; i <= 8; i++) begin
         l = 16'hA000 | 16'(i);
         r = 16'h5000 | 16'(i);
         run_slot(1'b0, w);
         checks++; if (w !== exp_word(l)) begin errors++; $display("FAIL fill_left%0d got %h expected %h", i, w, exp_word(l)); end
         run_slot(1'b1, w);
         checks++; if (w !== exp_word(r)) begin errors++; $display("FAIL fill_right%0d got %h expected %h", i, w, exp_word(r)); end
      end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL fill_drained got %0d expected 0", level); end
   endtask

   task automatic test_underflow;
      logic [31:0] w;
      int u0;
      u0 = uf_cycles;
      run_slot(1'b0, w);
      checks++; if (uf_cycles - u0 !== 1) begin errors++; $display("FAIL uf_pulse_cycles got %0d expected 1", uf_cycles - u0); end
      checks++; if (w !== 32'h0) begin errors++; $display("FAIL uf_left got %h expected 00000000", w); end
      run_slot(1'b1, w);
      checks++; if (w !== 32'h0) begin errors++; $display("FAIL uf_right got %h expected 00000000", w); end
`ifdef AUDIO_DAC_TX_UFLOW_CNT_EN
      checks++; if (ucount !== 16'd1) begin errors++; $display("FAIL uf_count got %h expected 0001", ucount); end
      force dut.uflow_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.uflow_cnt_q;
      run_slot(1'b0, w);
      checks++; if (ucount !== 16'hFFFF) begin errors++; $display("FAIL uf_count_sat got %h expected ffff", ucount); end
      run_slot(1'b1, w);
`endif
   endtask

   task automatic test_reset_mid;
      logic [31:0] w;
      logic [5:0] head;
      logic [25:0] tail;
      logic b;
      int u0;
      push_frame(16'hFFFF, 16'hFFFF);
      push_frame(16'h1234, 16'h4321);
      for (int i = 0; i < 6; i++) begin
         bclk_bit(i == 0, 1'b0, b);
         head[5-i] = b;
      end
      checks++; if (head !== 6'b011111) begin errors++; $display("FAIL mid_head got %b expected 011111", head); end
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL mid_level_pre got %0d expected 1", level); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL mid_rst_dacdat got %b expected 0", dacdat); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL mid_rst_level got %0d expected 0", level); end
      rst = 1'b0;
      @(negedge clk);
      u0 = uf_cycles;
      push_frame(16'hC3A5, 16'h5A3C);
      for (int i = 0; i < 26; i++) begin
         bclk_bit(1'b0, 1'b0, b);
         tail[25-i] = b;
      end
      checks++; if (tail !== 26'h0) begin errors++; $display("FAIL mid_tail got %h expected 0", tail); end
      run_slot(1'b1, w);
      checks++; if (w !== 32'h0) begin errors++; $display("FAIL mid_unaligned_right got %h expected 00000000", w); end
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL mid_level_held got %0d expected 1", level); end
      run_slot(1'b0, w);
      checks++; if (w !== exp_word(16'hC3A5)) begin errors++; $display("FAIL mid_left got %h expected %h", w, exp_word(16'hC3A5)); end
      run_slot(1'b1, w);
      checks++; if (w !== exp_word(16'h5A3C)) begin errors++; $display("FAIL mid_right got %h expected %h", w, exp_word(16'h5A3C)); end
      checks++; if (uf_cycles - u0 !== 0) begin errors++; $display("FAIL mid_underflow got %0d expected 0", uf_cycles - u0); end
   endtask

   task automatic test_coincident;
      logic [31:0] w;
      logic b0, b1, b2;
      push_frame(16'h8000, 16'h0001);
      run_slot(1'b0, w);
      b0 = w[31];
      b1 = w[30];
      b2 = w[29];
      checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL coin_no_shift got %b expected 0", b0); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL coin_msb got %b expected 1", b1); end
      checks++; if (b2 !== 1'b0) begin errors++; $display("FAIL coin_after_msb got %b expected 0", b2); end
      run_slot(1'b1, w);
      checks++; if (w !== exp_word(16'h0001)) begin errors++; $display("FAIL coin_right got %h expected %h", w, exp_word(16'h0001)); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_fill();
      test_underflow();
      test_reset_mid();
      test_coincident();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
